// File: rtl/mul_sched_if.sv
// Handshake bundle for mul_sched: two operand requesters
// plus the product response channel and busy flag.
interface mul_sched_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic               resp_valid;
  logic               resp_ready;
  logic               resp_id;
  logic [2*WIDTH-1:0] resp_product;

  logic busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_product,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_product,
    input  busy
  );
endinterface

// File: rtl/mul_sched.sv
// Two-requester scheduler for one iterative shift-add signed multiplier.
// Define MUL_SCHED_RR_EN for round-robin arbitration (else fixed priority).
module mul_sched #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  mul_sched_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    NEG,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic               sign_q, sign_d;
  logic               id_q, id_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic grant0, grant1;
  logic ready0, ready1;

  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   sum;

`ifdef MUL_SCHED_RR_EN
  logic ptr_q, ptr_d;

  // ptr=0 favours requester 0 on a tie
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
    grant1 = bus.req1_valid & (~bus.req0_valid | ptr_q);
  end
`else
  always_comb begin
    grant0 = bus.req0_valid;
    grant1 = bus.req1_valid & ~bus.req0_valid;
  end
`endif

  always_comb begin
    sel_a = grant1 ? bus.req1_a : bus.req0_a;
    sel_b = grant1 ? bus.req1_b : bus.req0_b;
    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude
    abs_a = sel_a[WIDTH-1] ? -sel_a : sel_a;
    abs_b = sel_b[WIDTH-1] ? -sel_b : sel_b;
  end

  always_comb begin
    if (acc_q[0])
      sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_q};
    else
      sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mag_a_d = mag_a_q;
    sign_d  = sign_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    ready0  = 1'b0;
    ready1  = 1'b0;
`ifdef MUL_SCHED_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        ready0 = grant0 & ~rst;
        ready1 = grant1 & ~rst;
        if (grant0 | grant1) begin
          mag_a_d = abs_a;
          acc_d   = {{WIDTH{1'b0}}, abs_b};
          sign_d  = sel_a[WIDTH-1] ^ sel_b[WIDTH-1];
          id_d    = grant1;
          cnt_d   = CW'(WIDTH);
          state_d = CALC;
`ifdef MUL_SCHED_RR_EN
          ptr_d   = ~grant1;
`endif
        end
      end
      CALC: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = NEG;
      end
      NEG: begin
        if (sign_q)
          acc_d = -acc_q;
        state_d = DONE;
      end
      DONE: begin
        if (bus.resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mag_a_q <= '0;
      sign_q  <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mag_a_q <= mag_a_d;
      sign_q  <= sign_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MUL_SCHED_RR_EN
  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= 1'b0;
    else
      ptr_q <= ptr_d;
  end
`endif

  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.resp_valid   = (state_q == DONE);
  assign bus.resp_id      = id_q;
  assign bus.resp_product = acc_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mul_sched.sv
// Directed-vector and random bench for mul_sched.
// Checks products, ids, latency, arbitration, stalls and reset abort.
module tb_mul_sched;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mul_sched_if #(.WIDTH(W)) bus();

  mul_sched #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t tv[11];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    return sa * sb;
  endfunction

  function automatic logic rdy(input logic id);
    return id ? bus.req1_ready : bus.req0_ready;
  endfunction

  task automatic drive(input logic id, input logic [31:0] a,
                       input logic [31:0] b);
    if (id) begin
      bus.req1_valid = 1'b1;
      bus.req1_a     = a;
      bus.req1_b     = b;
    end else begin
      bus.req0_valid = 1'b1;
      bus.req0_a     = a;
      bus.req0_b     = b;
    end
  endtask

  // Returns at #1 after the negedge of the grant cycle.
  task automatic issue(input logic id, input logic [31:0] a,
                       input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    drive(id, a, b);
    #1;
    while (!rdy(id) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant_seen", 64'(rdy(id)), 64'(1));
    chk("other_ready_low", 64'(rdy(~id)), 64'(0));
  endtask

  // Waits for the response handshake; bp randomises resp_ready.
  task automatic wait_resp(input string name, input logic id,
                           input logic [63:0] p, input bit chk_lat,
                           input bit bp);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      if (bp)
        bus.resp_ready = 1'($urandom_range(0, 1));
      #1;
      k++;
      if (chk_lat && k == 1) begin
        chk({name, "_busy"}, 64'(bus.busy), 64'(1));
        chk({name, "_ready_calc"}, 64'(bus.req0_ready | bus.req1_ready), 64'(0));
      end
    end while (!(bus.resp_valid && bus.resp_ready) && k < 400);
    chk({name, "_resp_valid"}, 64'(bus.resp_valid), 64'(1));
    if (chk_lat)
      chk({name, "_latency"}, 64'(k), 64'(W + 2));
    chk({name, "_product"}, bus.resp_product, p);
    chk({name, "_id"}, 64'(bus.resp_id), 64'(id));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rid;
    logic [63:0] held;
    int          n, bad;
    logic        gid;
    logic        exp_gid[4];

    tv[0]  = '{1'b0, 32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    tv[1]  = '{1'b1, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
    tv[2]  = '{1'b0, 32'hFFFF_FFFF,  32'd0,         64'h0};
    tv[3]  = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'h1};
    tv[4]  = '{1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    tv[5]  = '{1'b1, 32'h8000_0000,  32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
    tv[6]  = '{1'b0, 32'h8000_0000,  32'd1,         64'hFFFF_FFFF_8000_0000};
    tv[7]  = '{1'b1, 32'd0,          32'hFFFF_FFFB, 64'h0};
    tv[8]  = '{1'b0, 32'd100,        32'd200,       64'd20000};
    tv[9]  = '{1'b1, 32'hFFFF_FC18,  32'hFFFF_FC18, 64'd1000000};
    tv[10] = '{1'b0, 32'h0001_0000,  32'h0001_0000, 64'h1_0000_0000};

    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.resp_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("rst_resp_id", 64'(bus.resp_id), 64'(0));
    chk("rst_product", bus.resp_product, 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    bus.req0_valid = 1'b1;
    #1;
    chk("rst_ready0", 64'(bus.req0_ready), 64'(0));
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_busy", 64'(bus.busy), 64'(0));
    chk("idle_resp_valid", 64'(bus.resp_valid), 64'(0));

    // directed vectors
    for (int i = 0; i < 11; i++) begin
      issue(tv[i].id, tv[i].a, tv[i].b);
      wait_resp($sformatf("vec%0d", i), tv[i].id, tv[i].p, 1'b1, 1'b0);
    end

    // arbitration with both requesters valid continuously
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef MUL_SCHED_RR_EN
    exp_gid = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_gid = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    drive(1'b0, 32'd2, 32'd3);
    drive(1'b1, 32'd4, 32'd5);
    for (int g = 0; g < 4; g++) begin
      n = 0;
      #1;
      while (!(bus.req0_ready | bus.req1_ready) && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("arb_one_ready", 64'(bus.req0_ready ^ bus.req1_ready), 64'(1));
      gid = bus.req1_ready;
      chk($sformatf("arb_grant%0d", g), 64'(gid), 64'(exp_gid[g]));
      n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
        if (bus.req1_ready)
          bad++;
      end while (!bus.resp_valid && n < 100);
      chk($sformatf("arb_id%0d", g), 64'(bus.resp_id), 64'(exp_gid[g]));
      chk($sformatf("arb_prod%0d", g), bus.resp_product,
          exp_gid[g] ? 64'd20 : 64'd6);
      if (g == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      @(negedge clk);
    end

    // back-pressure: DONE held for 10 cycles
    bus.resp_ready = 1'b0;
    issue(1'b0, 32'd6, 32'hFFFF_FFF9);
    n = 0;
    do begin
      @(negedge clk);
      bus.req0_valid = 1'b0;
      #1;
      n++;
    end while (!bus.resp_valid && n < 100);
    chk("bp_resp_valid", 64'(bus.resp_valid), 64'(1));
    held = bus.resp_product;
    chk("bp_product", held, 64'hFFFF_FFFF_FFFF_FFD6);
    drive(1'b1, 32'd3, 32'd4);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (bus.resp_product !== held || bus.resp_id !== 1'b0 ||
          bus.req0_ready || bus.req1_ready || !bus.busy || !bus.resp_valid)
        bad++;
    end
    chk("bp_stall_stable", 64'(bad), 64'(0));
    bus.resp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_release_grant", 64'(bus.req1_ready), 64'(1));
    chk("bp_release_idle", 64'(bus.busy), 64'(0));
    wait_resp("bp_next", 1'b1, 64'd12, 1'b1, 1'b0);

    // reset during CALC cycle 10
    issue(1'b0, 32'd5, 32'd9);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      bus.req0_valid = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'd8, 32'd8);
    #1;
    chk("abort_busy_before", 64'(bus.busy), 64'(1));
    chk("abort_ready_rst", 64'(bus.req1_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.resp_valid)
        bad++;
    end
    chk("abort_no_resp", 64'(bad), 64'(0));
    issue(1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFE);
    wait_resp("abort_fresh", 1'b0, 64'hFFFF_FFFF_0000_0002, 1'b1, 1'b0);

    // random operands, random requester, random back-pressure
    for (int r = 0; r < 250; r++) begin
      rid = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      if (r % 7 == 0)
        ra = 32'h8000_0000;
      if (r % 11 == 0)
        rb = 32'h0;
      if (r % 13 == 0)
        rb = 32'hFFFF_FFFF;
      issue(rid, ra, rb);
      wait_resp("rand", rid, ref_mul(ra, rb), 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
